capture_strobe_gen: RTL
=======================

Name: capture_strobe_gen

Overview:
Drives the capture-control level signals (rst_capture, start, capture) that the downstream edge detectors consume. A single trigger launches a timed sequence with programmable widths and gaps. Every output returns low between pulses, so each pulse presents a clean rising edge to the receiver. It sits on the control side ahead of the capture datapath and reports sequence completion back to the initiator.

Parameters:
CNT_W, 8, width of all width, gap and count configuration inputs and of the internal counters.

Ports:
clk_i  input  1  clock
rst_an_i  input  1  reset, asynchronous, active-low
trig_i  input  1  sequence request; sampled only in IDLE
abort_i  input  1  synchronous abort of any sequence in progress
rst_width_i  input  CNT_W  rst_capture_o high time, in cycles
start_width_i  input  CNT_W  start_o high time, in cycles
cap_width_i  input  CNT_W  capture_o high time per pulse, in cycles
cap_gap_i  input  CNT_W  capture_o low time between pulses, in cycles
cap_count_i  input  CNT_W  number of capture pulses
rst_capture_o  output  1  capture-reset level
start_o  output  1  start level
capture_o  output  1  capture level
busy_o  output  1  sequence in progress
done_o  output  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0. All outputs are driven directly from flops, with no combinational path from inputs to outputs.
- FSM states and transitions:
  - IDLE: trig_i=1 and abort_i=0 latches all config inputs into shadow registers and moves to RST.
  - RST: rst_capture_o=1 for rst_w cycles, then START.
  - START: start_o=1 for start_w cycles. Then CAP_HI if cnt>0, else DONE.
  - CAP_HI: capture_o=1 for cap_w cycles. Then CAP_LO if further pulses remain, else DONE.
  - CAP_LO: all outputs low for gap_w cycles, then CAP_HI.
  - DONE: one cycle; done_o=1; all level outputs 0. Then IDLE.
- Width rule: any width or gap config value of 0 is treated as 1. A phase therefore lasts at least one cycle, and the receiver always sees at least one low cycle between capture pulses. cap_count 0 is a true zero and skips the capture phase.
- Latency: trig_i sampled high at clock edge N gives rst_capture_o=1 from edge N+1.
- Phase boundaries: on the edge where one level drops, the next phase's level rises on that same edge. No overlap and no dead cycle between different signals.
- busy_o: 1 in every non-IDLE state, including DONE. It is 0 in the cycle trig_i is sampled.
- Config is used only from the shadow registers; input changes mid-sequence have no effect.
- trig_i while busy: ignored and not queued. A trigger sampled in IDLE the cycle after DONE is accepted.
- abort_i=1 in any non-IDLE state: next edge goes to IDLE with all outputs 0. No done_o is issued.
- abort_i and trig_i together in IDLE: abort wins and no sequence starts.
- Total sequence length in cycles: rst_w + start_w + cnt*cap_w + (cnt-1)*gap_w + 1, with the gap term taken as 0 when cnt=0.
- Counters are down-counters. No overflow is possible because loads are at most 2^CNT_W-1.
- rst_an_i asserted mid-sequence: all outputs 0 immediately (asynchronous), FSM to IDLE.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, RST, START, CAP_HI, CAP_LO, DONE.
  - Default CNT_W.
- One sub-module is natural: strobe_timer. It is a loadable down-counter with zero-to-one clamp, expire flag and load/enable inputs, used for phase timing. A second instance counts remaining pulses.

Test Plan:
- Basic sequence:
  - Stimulus: widths rst=2, start=3, cap=1, gap=2, count=3; trig at edge 0.
  - Response: rst_capture_o high edges 1-2; start_o high 3-5; capture_o high at 6, 9, 12; done_o at 13; busy_o 1-13.
- Zero clamps:
  - Stimulus: all widths 0, count=2.
  - Response: rst 1 cycle, start 1 cycle, capture high/low/high, done; total 6 cycles.
- No capture pulses:
  - Stimulus: count=0, rst=1, start=1.
  - Response: capture_o never asserts; done_o at edge 3.
- Abort mid-sequence:
  - Stimulus: abort_i during the second capture pulse.
  - Response: all outputs 0 next edge, no done_o.
  - Follow-up: a new trig the next cycle is accepted.
- Trigger while busy and config change mid-run:
  - Stimulus: trig while busy; change cap_width_i mid-run.
  - Response: no restart; the original widths are kept. abort_i and trig_i together in IDLE produce no busy_o.
- Async reset:
  - Stimulus: rst_an_i low mid-START.
  - Response: start_o and busy_o drop without a clock. After release, the block stays idle until the next trig.

Source files
------------

// File: rtl/capture_strobe_gen_pkg.sv
// Shared types for the capture strobe generator:
// FSM state encoding and default counter width.
package capture_strobe_gen_pkg;

   localparam int CNT_W_DEF = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_START,
      S_CAP_HI,
      S_CAP_LO,
      S_DONE
   } state_e;

endpackage

// File: rtl/capture_strobe_gen_if.sv
// Trigger/config/strobe bundle between the initiator
// and the capture strobe generator.
interface capture_strobe_gen_if #(
   parameter int CNT_W = capture_strobe_gen_pkg::CNT_W_DEF
);

   logic             trig_i;
   logic             abort_i;
   logic [CNT_W-1:0] rst_width_i;
   logic [CNT_W-1:0] start_width_i;
   logic [CNT_W-1:0] cap_width_i;
   logic [CNT_W-1:0] cap_gap_i;
   logic [CNT_W-1:0] cap_count_i;
   logic             rst_capture_o;
   logic             start_o;
   logic             capture_o;
   logic             busy_o;
   logic             done_o;

   modport master (
      output trig_i, abort_i,
      output rst_width_i, start_width_i,
      output cap_width_i, cap_gap_i, cap_count_i,
      input  rst_capture_o, start_o, capture_o,
      input  busy_o, done_o
   );

   modport slave (
      input  trig_i, abort_i,
      input  rst_width_i, start_width_i,
      input  cap_width_i, cap_gap_i, cap_count_i,
      output rst_capture_o, start_o, capture_o,
      output busy_o, done_o
   );

endinterface

// File: rtl/capture_strobe_gen_strobe_timer.sv
// Loadable down-counter with optional zero-to-one clamp;
// expire_o flags the final counted cycle (count <= 1).
module capture_strobe_gen_strobe_timer #(
   parameter int CNT_W = 8,
   parameter bit CLAMP = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_an_i,
   input  logic             load_i,
   input  logic             dec_i,
   input  logic [CNT_W-1:0] val_i,
   output logic             expire_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         if (CLAMP && (val_i == '0)) cnt_d = CNT_W'(1);
         else                        cnt_d = val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_an_i) begin
      if (!rst_an_i) cnt_q <= '0;
      else           cnt_q <= cnt_d;
   end

   assign expire_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/capture_strobe_gen.sv
// Timed rst_capture/start/capture level sequencer with
// registered outputs, abort and completion pulse.
module capture_strobe_gen
   import capture_strobe_gen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_an_i,
   capture_strobe_gen_if.slave  bus
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] start_w_q, start_w_d;
   logic [CNT_W-1:0] cap_w_q, cap_w_d;
   logic [CNT_W-1:0] gap_w_q, gap_w_d;
   logic             none_q, none_d;

   logic             ph_load, ph_dec, ph_exp;
   logic [CNT_W-1:0] ph_val;
   logic             pc_load, pc_dec, pc_last;

   logic rst_cap_q, start_q, cap_q, busy_q, done_q;

   capture_strobe_gen_strobe_timer #(
      .CNT_W (CNT_W),
      .CLAMP (1'b1)
   ) u_phase_timer (
      .clk_i    (clk_i),
      .rst_an_i (rst_an_i),
      .load_i   (ph_load),
      .dec_i    (ph_dec),
      .val_i    (ph_val),
      .expire_o (ph_exp)
   );

   // Pulse count is a true zero, so no clamp here.
   capture_strobe_gen_strobe_timer #(
      .CNT_W (CNT_W),
      .CLAMP (1'b0)
   ) u_pulse_timer (
      .clk_i    (clk_i),
      .rst_an_i (rst_an_i),
      .load_i   (pc_load),
      .dec_i    (pc_dec),
      .val_i    (bus.cap_count_i),
      .expire_o (pc_last)
   );

   always_comb begin
      state_d   = state_q;
      start_w_d = start_w_q;
      cap_w_d   = cap_w_q;
      gap_w_d   = gap_w_q;
      none_d    = none_q;
      ph_load   = 1'b0;
      ph_val    = cap_w_q;
      ph_dec    = (state_q != S_IDLE);
      pc_load   = 1'b0;
      pc_dec    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.trig_i) begin
               state_d   = S_RST;
               ph_load   = 1'b1;
               ph_val    = bus.rst_width_i;
               pc_load   = 1'b1;
               start_w_d = bus.start_width_i;
               cap_w_d   = bus.cap_width_i;
               gap_w_d   = bus.cap_gap_i;
               none_d    = (bus.cap_count_i == '0);
            end
         end
         S_RST: begin
            if (ph_exp) begin
               state_d = S_START;
               ph_load = 1'b1;
               ph_val  = start_w_q;
            end
         end
         S_START: begin
            if (ph_exp) begin
               if (none_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_CAP_HI;
                  ph_load = 1'b1;
                  ph_val  = cap_w_q;
               end
            end
         end
         S_CAP_HI: begin
            if (ph_exp) begin
               if (pc_last) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_CAP_LO;
                  ph_load = 1'b1;
                  ph_val  = gap_w_q;
                  pc_dec  = 1'b1;
               end
            end
         end
         S_CAP_LO: begin
            if (ph_exp) begin
               state_d = S_CAP_HI;
               ph_load = 1'b1;
               ph_val  = cap_w_q;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Abort beats everything, including a trigger in IDLE.
      if (bus.abort_i) state_d = S_IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_an_i) begin
      if (!rst_an_i) begin
         state_q   <= S_IDLE;
         start_w_q <= '0;
         cap_w_q   <= '0;
         gap_w_q   <= '0;
         none_q    <= 1'b0;
         rst_cap_q <= 1'b0;
         start_q   <= 1'b0;
         cap_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         start_w_q <= start_w_d;
         cap_w_q   <= cap_w_d;
         gap_w_q   <= gap_w_d;
         none_q    <= none_d;
         rst_cap_q <= (state_d == S_RST);
         start_q   <= (state_d == S_START);
         cap_q     <= (state_d == S_CAP_HI);
         busy_q    <= (state_d != S_IDLE);
         done_q    <= (state_d == S_DONE);
      end
   end

   assign bus.rst_capture_o = rst_cap_q;
   assign bus.start_o       = start_q;
   assign bus.capture_o     = cap_q;
   assign bus.busy_o        = busy_q;
   assign bus.done_o        = done_q;

endmodule
